// File: rtl/bitstream_pkg.sv
// Shared types for the stochastic bitstream decoder: FSM states and default value width.
package bitstream_pkg;

  localparam int unsigned VALUE_LEN_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_e;

endpackage

// File: rtl/bit_window_counter.sv
// Window counter: counts samples taken and ones seen over a window of 2**VALUE_LEN-1 cycles.
module bit_window_counter
  import bitstream_pkg::*;
#(
  parameter int unsigned VALUE_LEN = VALUE_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 bit_in,
  output logic [VALUE_LEN-1:0] count,
  output logic                 done
);

  localparam logic [VALUE_LEN-1:0] LAST_CYCLE = VALUE_LEN'((2 ** VALUE_LEN) - 2);

  logic [VALUE_LEN-1:0] cycles;

  // done marks the W-th sample; count excludes the bit being sampled in that cycle
  assign done = enable && (cycles == LAST_CYCLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cycles <= '0;
      count  <= '0;
    end else if (clear) begin
      cycles <= '0;
      count  <= '0;
    end else if (enable) begin
      if (done) begin
        cycles <= '0;
        count  <= '0;
      end else begin
        cycles <= cycles + 1'b1;
        count  <= count + VALUE_LEN'(bit_in);
      end
    end
  end

endmodule

// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over a fixed window and hands the result to a consumer.
// Optional macro BITSTREAM_DECODER_CONT_EN: back-to-back windows with sticky overrun detection.
module bitstream_decoder
  import bitstream_pkg::*;
#(
  parameter int unsigned VALUE_LEN = VALUE_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 bit_in,
  input  logic                 start,
  input  logic                 out_ready,
  output logic [VALUE_LEN-1:0] value,
  output logic                 value_valid,
  output logic                 busy,
  output logic                 overrun
);

  state_e               state_q, state_d;
  logic                 clear, enable, done, accept;
  logic [VALUE_LEN-1:0] count;

  bit_window_counter #(.VALUE_LEN(VALUE_LEN)) u_counter (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (clear),
    .enable (enable),
    .bit_in (bit_in),
    .count  (count),
    .done   (done)
  );

  assign accept = value_valid && out_ready;
  assign busy   = (state_q == COUNT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    enable  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        enable = 1'b1;
`ifdef BITSTREAM_DECODER_CONT_EN
        state_d = COUNT;
`else
        if (done) state_d = HOLD;
`endif
      end
      HOLD: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A completing window takes priority over acceptance so a fresh result is never dropped
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value       <= '0;
      value_valid <= 1'b0;
    end else if (done) begin
      value       <= count + VALUE_LEN'(bit_in);
      value_valid <= 1'b1;
    end else if (accept) begin
      value_valid <= 1'b0;
    end
  end

`ifdef BITSTREAM_DECODER_CONT_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                        overrun_q <= 1'b0;
    else if (done && value_valid && !out_ready) overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed bench for bitstream_decoder at VALUE_LEN=4 (window of 15 samples).
module tb_bitstream_decoder;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       bit_in;
  logic       start;
  logic       out_ready;
  logic [3:0] value;
  logic       value_valid;
  logic       busy;
  logic       overrun;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  bitstream_decoder #(.VALUE_LEN(4)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .bit_in      (bit_in),
    .start       (start),
    .out_ready   (out_ready),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one window: start pulse, then pattern[0..14] as samples 1..15
  task automatic run_window(input string tag, input logic [14:0] pattern,
                            input logic [3:0] exp, input logic noisy);
    start = 1'b1;
    tick();
    start = noisy;
    for (int i = 0; i < 15; i++) begin
      bit_in = pattern[i];
      if (i == 0)  check({tag, "_busy_first"}, busy, 1'b1);
      if (i == 14) check({tag, "_valid_early"}, value_valid, 1'b0);
      tick();
    end
    bit_in = 1'b0;
    start  = 1'b0;
    check({tag, "_value"}, value, exp);
    check({tag, "_valid"}, value_valid, 1'b1);
    check({tag, "_busy_done"}, busy, 1'b0);
  endtask

  task automatic accept_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_cleared"}, value_valid, 1'b0);
  endtask

  initial begin
    n_rst     = 1'b0;
    bit_in    = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_value", value, 4'd0);
    check("rst_valid", value_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    n_rst = 1'b1;
    tick();
    tick();
    check("idle_busy", busy, 1'b0);

`ifdef BITSTREAM_DECODER_CONT_EN
    // Continuous mode: all ones, never accepted
    bit_in = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("cont_valid_early", value_valid, 1'b0);
    tick();
    check("cont_value1", value, 4'd15);
    check("cont_valid1", value_valid, 1'b1);
    check("cont_busy1", busy, 1'b1);
    check("cont_overrun1", overrun, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    check("cont_value2", value, 4'd15);
    check("cont_overrun2", overrun, 1'b1);
    check("cont_busy2", busy, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("cont_accept_valid", value_valid, 1'b0);
    check("cont_accept_busy", busy, 1'b1);
    check("cont_overrun_sticky", overrun, 1'b1);
    bit_in = 1'b0;
`else
    run_window("ones", 15'h7fff, 4'd15, 1'b0);
    accept_result("ones");
    check("ones_value_kept", value, 4'd15);

    run_window("alt", 15'h5555, 4'd8, 1'b0);
    accept_result("alt");

    run_window("zeros", 15'h0000, 4'd0, 1'b0);
    accept_result("zeros");

    // Starts during COUNT and HOLD, consumer stalls 10 cycles
    run_window("stall", 15'h7fff, 4'd15, 1'b1);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_value", value, 4'd15);
      check("stall_valid", value_valid, 1'b1);
      check("stall_busy", busy, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_accept_valid", value_valid, 1'b0);
    check("stall_accept_busy", busy, 1'b0);
    start = 1'b0;
    tick();
    check("stall_idle_busy", busy, 1'b0);
    check("stall_value_held", value, 4'd15);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_ready_ignored", value_valid, 1'b0);

    // Reset in the middle of a window, at sample 7
    start = 1'b1;
    tick();
    start  = 1'b0;
    bit_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst_value", value, 4'd0);
    check("midrst_valid", value_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    tick();
    n_rst  = 1'b1;
    bit_in = 1'b0;
    tick();
    tick();
    check("postrst_busy", busy, 1'b0);
    check("postrst_valid", value_valid, 1'b0);
    run_window("postrst", 15'h5555, 4'd8, 1'b0);

    // Unaccepted result left standing: no overrun without the continuous option
    for (int i = 0; i < 20; i++) tick();
    check("noncont_overrun", overrun, 1'b0);
    check("noncont_busy", busy, 1'b0);
    check("noncont_value", value, 4'd8);
    accept_result("postrst");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
